// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
package pipe_ctrl_pkg;
  localparam int REG_W  = 5;
  localparam int WAIT_W = 8;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard request inputs and hold/flush/bubble outputs.
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rt;
  logic             ex_branch_taken;
  logic             id_jump;
  logic             mem_req;
  logic             mem_ready;
  logic             clr_stats;
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_freeze;
  logic             memwb_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt,
           ex_branch_taken, id_jump, mem_req, mem_ready, clr_stats,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze,
           memwb_bubble, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt,
           ex_branch_taken, id_jump, mem_req, mem_ready, clr_stats,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze,
           memwb_bubble, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use, branch/jump squash and
// data-memory wait freeze with timeout, plus stall/flush statistics.
//   state       | meaning
//   ST_RUN      | no memory wait outstanding
//   ST_MEM_WAIT | pipeline frozen on a data access, wait_cnt counting
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int          CNT_W   = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hif
);
  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic load_use, timeout_hit, mem_wait;
  logic pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze, memwb_bubble;

  always_comb begin
    load_use = hif.ex_memread && (hif.ex_rt != REG_ZERO) &&
               ((hif.id_uses_rs && (hif.id_rs == hif.ex_rt)) ||
                (hif.id_uses_rt && (hif.id_rt == hif.ex_rt)));
    timeout_hit = (state_q == ST_MEM_WAIT) && (wait_cnt_q == TIMEOUT_C);
    mem_wait    = hif.mem_req && !hif.mem_ready && !timeout_hit;
  end

  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    pipe_freeze  = 1'b0;
    memwb_bubble = 1'b0;
    if (mem_wait) begin
      pc_hold      = 1'b1;
      ifid_hold    = 1'b1;
      pipe_freeze  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (hif.ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      // Jump in ID is held here and redirects once the load has moved on.
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end else if (hif.id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (hif.mem_req && !hif.mem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!hif.mem_req || hif.mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (timeout_hit) begin
          state_d       = ST_RUN;
          wait_cnt_d    = '0;
          mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
    if (hif.clr_stats)
      mem_timeout_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_hold),
    .clr   (hif.clr_stats),
    .cnt   (hif.stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifid_flush),
    .clr   (hif.clr_stats),
    .cnt   (hif.flush_cnt)
  );

  assign hif.pc_hold      = pc_hold;
  assign hif.ifid_hold    = ifid_hold;
  assign hif.ifid_flush   = ifid_flush;
  assign hif.idex_bubble  = idex_bubble;
  assign hif.pipe_freeze  = pipe_freeze;
  assign hif.memwb_bubble = memwb_bubble;
  assign hif.mem_timeout  = mem_timeout_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with a queue-based scoreboard.
module tb_hazard_ctrl;
  localparam logic [5:0] H0  = 6'b000000;
  localparam logic [5:0] HLU = 6'b110100;
  localparam logic [5:0] HBR = 6'b001100;
  localparam logic [5:0] HJ  = 6'b001000;
  localparam logic [5:0] HMW = 6'b110011;

  typedef struct packed {
    int          idx;
    logic [5:0]  haz;
    logic        to;
    logic [15:0] st;
    logic [15:0] fl;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec   = 0;

  hazard_ctrl_if #(.CNT_W(16)) hif ();

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic [4:0] rs, rt, input logic urs, urt, mr,
                        input logic [4:0] exrt, input logic br, jmp, mq, my, clr);
    hif.id_rs = rs;  hif.id_rt = rt;  hif.id_uses_rs = urs;  hif.id_uses_rt = urt;
    hif.ex_memread = mr;  hif.ex_rt = exrt;  hif.ex_branch_taken = br;
    hif.id_jump = jmp;  hif.mem_req = mq;  hif.mem_ready = my;  hif.clr_stats = clr;
  endtask

  task automatic drv(input logic [4:0] rs, rt, input logic urs, urt, mr,
                     input logic [4:0] exrt, input logic br, jmp, mq, my, clr,
                     input logic [5:0] ehaz, input logic eto,
                     input logic [15:0] est, efl);
    exp_t e;
    @(posedge clk);
    #1;
    set_in(rs, rt, urs, urt, mr, exrt, br, jmp, mq, my, clr);
    e.idx = vec; e.haz = ehaz; e.to = eto; e.st = est; e.fl = efl;
    sb_q.push_back(e);
    vec++;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [5:0] haz;
      e   = sb_q.pop_front();
      haz = {hif.pc_hold, hif.ifid_hold, hif.ifid_flush, hif.idex_bubble,
             hif.pipe_freeze, hif.memwb_bubble};
      n_cmp++;
      if (haz !== e.haz || hif.mem_timeout !== e.to ||
          hif.stall_cnt !== e.st || hif.flush_cnt !== e.fl) begin
        n_bad++;
        $display("FAIL vec%0d: got haz=%b to=%b stall=%0d flush=%0d, want haz=%b to=%b stall=%0d flush=%0d",
                 e.idx, haz, hif.mem_timeout, hif.stall_cnt, hif.flush_cnt,
                 e.haz, e.to, e.st, e.fl);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set_in(0,0,0,0,0,0,0,0,0,0,0);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    //   rs rt urs urt mr exrt br jmp mq my clr | haz to stall flush
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H0,  0, 0,  0);  // 0 reset state
    drv(8, 0, 1, 0, 1, 8, 0, 0, 0, 0, 0,  HLU, 0, 0,  0);  // 1 load-use on rs
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H0,  0, 1,  0);
    drv(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  H0,  0, 1,  0);  // 3 ex_rt=$0
    drv(0, 9, 0, 1, 1, 9, 0, 0, 0, 0, 0,  HLU, 0, 1,  0);  // 4 load-use on rt
    drv(9, 2, 0, 1, 1, 9, 0, 0, 0, 0, 0,  H0,  0, 2,  0);  // 5 rs match, not read
    drv(8, 0, 1, 0, 1, 8, 1, 0, 0, 0, 0,  HBR, 0, 2,  0);  // 6 branch beats load-use
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  HJ,  0, 2,  1);  // 7 jump only
    drv(8, 0, 1, 0, 1, 8, 0, 1, 0, 0, 0,  HLU, 0, 2,  2);  // 8 load-use beats jump
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  HJ,  0, 3,  2);  // 9 jump next cycle
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H0,  0, 3,  3);
    drv(8, 0, 1, 0, 1, 8, 1, 1, 1, 0, 0,  HMW, 0, 3,  3);  // 11 wait beats all
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  HMW, 0, 4,  3);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  HMW, 0, 5,  3);
    drv(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0,  HBR, 0, 6,  3);  // 14 ready releases
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  HMW, 0, 6,  4);  // 15 timeout run
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  HMW, 0, 7,  4);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  HMW, 0, 8,  4);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  HMW, 0, 9,  4);
    drv(8, 0, 1, 0, 1, 8, 0, 0, 1, 0, 0,  HLU, 0, 10, 4);  // 19 timeout release
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H0,  1, 11, 4);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H0,  1, 11, 4);  // 21 sticky
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  H0,  1, 11, 4);  // 22 clr_stats
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H0,  0, 0,  0);
    drv(8, 0, 1, 0, 1, 8, 0, 0, 0, 0, 1,  HLU, 0, 0,  0);  // 24 clr beats inc
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H0,  0, 0,  0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  HJ,  0, 0,  0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  HMW, 0, 0,  1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  HMW, 0, 1,  1);  // 28 mid-wait

    @(negedge clk);
    #2;
    reset = 1'b0;
    set_in(0,0,0,0,0,0,0,0,0,0,0);
    @(posedge clk);
    #1 reset = 1'b1;

    // A fresh wait must freeze four full cycles again after reset.
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  HMW, 0, 0,  0);  // 29
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  HMW, 0, 1,  0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  HMW, 0, 2,  0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  HMW, 0, 3,  0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  H0,  0, 4,  0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  H0,  1, 4,  0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
